pwm_update_scheduler: RTL and testbench

//  Consumes the five SPI-written config registers and drives 16 output channels: ch[15:0].

---
 rtl/pwm_update_scheduler_pkg.sv | 31 +++
 rtl/pwm_update_scheduler_if.sv | 29 ++
 rtl/pwm_tick_gen.sv | 29 ++
 rtl/pwm_update_scheduler.sv | 88 ++++++++
 tb/tb_pwm_update_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_update_scheduler_pkg.sv
// Shared definitions for the PWM update scheduler and the SPI register file.
// Register map, channel geometry and the shadowed configuration bundle.
package pwm_update_scheduler_pkg;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  localparam int NUM_CH    = 16;
  localparam int STEP_BITS = 8;

  localparam logic [7:0] DUTY_FULL = 8'hFF;
  localparam logic [STEP_BITS-1:0] STEP_LAST = '1;

  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [7:0]        duty;
  } cfg_t;

  // Full-scale duty is 100% high rather than 255/256.
  function automatic logic pwm_lvl(
    input logic [7:0]           duty,
    input logic [STEP_BITS-1:0] step
  );
    return (duty == DUTY_FULL) || (step < duty);
  endfunction

endpackage

// File: rtl/pwm_update_scheduler_if.sv
// Config-in / channel-out bundle between the SPI register file,
// the update scheduler and the output pins.
interface pwm_update_scheduler_if;
  import pwm_update_scheduler_pkg::*;

  logic [7:0]        en_out_lo;
  logic [7:0]        en_out_hi;
  logic [7:0]        en_pwm_lo;
  logic [7:0]        en_pwm_hi;
  logic [7:0]        duty;
  logic [NUM_CH-1:0] ch;
  logic              period_start;
  logic              update_pending;

  modport master (
    output en_out_lo, en_out_hi,
    output en_pwm_lo, en_pwm_hi,
    output duty,
    input  ch, period_start, update_pending
  );

  modport slave (
    input  en_out_lo, en_out_hi,
    input  en_pwm_lo, en_pwm_hi,
    input  duty,
    output ch, period_start, update_pending
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// PWM step prescaler: one tick every PRESCALE clocks.
// PRESCALE = 1 gives a tick on every cycle.
module pwm_tick_gen #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  assign tick_o = (pcnt_q == PLAST);

  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (tick_o) pcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Double-buffered 16-channel PWM output stage; new config is
// applied only at period boundaries (or at once while idle).
module pwm_update_scheduler
  import pwm_update_scheduler_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input logic                  clk,
  input logic                  rst_n,
  pwm_update_scheduler_if.slave bus
);

  logic tick;
  logic boundary;
  logic commit;
  logic lvl;

  logic [STEP_BITS-1:0] scnt_q;
  logic [STEP_BITS-1:0] scnt_d;

  cfg_t live;
  cfg_t shadow_q;
  cfg_t shadow_d;

  logic [NUM_CH-1:0] ch_q;
  logic [NUM_CH-1:0] ch_d;

  logic ps_q;
  logic pend_q;
  logic pend_d;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign live = {
    bus.en_out_hi, bus.en_out_lo,
    bus.en_pwm_hi, bus.en_pwm_lo,
    bus.duty
  };

  always_comb begin
    scnt_d   = scnt_q;
    boundary = 1'b0;
    commit   = 1'b0;
    shadow_d = shadow_q;
    pend_d   = (live != shadow_q);
    lvl      = pwm_lvl(shadow_q.duty, scnt_q);
    ch_d     = '0;

    if (tick) scnt_d = scnt_q + STEP_BITS'(1);
    boundary = tick && (scnt_q == STEP_LAST);

    // With every output disabled nothing can glitch, so track live.
    commit = boundary || (shadow_q.en_out == '0);
    if (commit) shadow_d = live;

    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = shadow_q.en_out[i] &
                (~shadow_q.en_pwm[i] | lvl);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q   <= '0;
      shadow_q <= '0;
      ch_q     <= '0;
      ps_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      scnt_q   <= scnt_d;
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
      ps_q     <= boundary;
      pend_q   <= pend_d;
    end
  end

  assign bus.ch             = ch_q;
  assign bus.period_start   = ps_q;
  assign bus.update_pending = pend_q;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Scoreboard bench for pwm_update_scheduler: per-cycle reference model
// plus directed period-level checks at PRESCALE=2 and PRESCALE=13.
module tb_pwm_update_scheduler;

  localparam int P  = 2;
  localparam int P2 = 13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  always #5 clk = ~clk;

  pwm_update_scheduler_if bus ();
  pwm_update_scheduler_if bus2 ();

  pwm_update_scheduler #(.PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pwm_update_scheduler #(.PRESCALE(P2)) dut13 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
  } m_cfg_t;

  typedef struct packed {
    logic [15:0] ch;
    logic        ps;
    logic        pend;
  } obs_t;

  obs_t   exp_q[$];
  obs_t   m_e;
  obs_t   m_o;
  m_cfg_t m_sh;
  m_cfg_t m_live;
  longint m_n;
  int     m_step;
  bit     m_bnd;
  bit     m_lvl;

  // Reference model: time since reset release determines the PWM step.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0;
      m_sh = '0;
      exp_q.delete();
    end else begin
      m_live = {bus.en_out_hi, bus.en_out_lo,
                bus.en_pwm_hi, bus.en_pwm_lo, bus.duty};
      m_step = int'((m_n / P) % 256);
      m_bnd  = ((m_n % P) == P - 1) && (m_step == 255);
      m_lvl  = (m_sh.d == 8'hFF) || (m_step < int'(m_sh.d));
      for (int i = 0; i < 16; i++)
        m_o.ch[i] = m_sh.eo[i] ? (m_sh.ep[i] ? m_lvl : 1'b1) : 1'b0;
      m_o.ps   = m_bnd;
      m_o.pend = (m_live != m_sh);
      exp_q.push_back(m_o);
      if (m_bnd || m_sh.eo == 16'h0) m_sh = m_live;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("sb_ch", int'(bus.ch), int'(m_e.ch));
      chk("sb_period_start", int'(bus.period_start), int'(m_e.ps));
      chk("sb_update_pending", int'(bus.update_pending), int'(m_e.pend));
    end
  end

  task automatic wait_ps(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.period_start && k < 2000);
    chk("wait_period_start", int'(bus.period_start), 1);
  endtask

  // Called on the negedge where period_start is visible; ends on the next one.
  task automatic measure(input int chg_at, input logic [7:0] nd,
                         output int hi, output int pm);
    hi = 0;
    pm = 0;
    for (int i = 0; i < 512; i++) begin
      if (bus.ch[0]) hi++;
      if (i == chg_at) bus.duty = nd;
      if (chg_at >= 0 && i == chg_at + 2) pm = int'(bus.update_pending);
      @(negedge clk);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        logic [7:0] v;
        v = 8'($urandom);
        case ($urandom_range(0, 6))
          0: bus.en_out_lo = v;
          1: bus.en_out_hi = v;
          2: bus.en_pwm_lo = v;
          3: bus.en_pwm_hi = v;
          4: bus.duty = v;
          5: begin bus.en_out_lo = 8'h00; bus.en_out_hi = 8'h00; end
          default: bus.duty = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01;
        endcase
      end
    end
  endtask

  initial begin
    int k, hi, pm;
    bus.en_out_lo = 0; bus.en_out_hi = 0;
    bus.en_pwm_lo = 0; bus.en_pwm_hi = 0; bus.duty = 0;
    bus2.en_out_lo = 8'h01; bus2.en_out_hi = 8'h80;
    bus2.en_pwm_lo = 8'h01; bus2.en_pwm_hi = 8'h80; bus2.duty = 8'd100;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_ch", int'(bus.ch), 0);
    chk("reset_pending", int'(bus.update_pending), 0);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    fork
      begin
        rand_cycles(300);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ch", int'(bus.ch), 0);
        chk("midreset_pending", int'(bus.update_pending), 0);
        chk("midreset_ps", int'(bus.period_start), 0);
        bus.en_out_lo = 0; bus.en_out_hi = 0;
        bus.en_pwm_lo = 0; bus.en_pwm_hi = 0; bus.duty = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ps(k);
        chk("restart_first_period", k, 512);

        bus.en_out_lo = 8'h01;
        @(posedge clk);
        @(posedge clk);
        #1 chk("idle_fastpath_ch0", int'(bus.ch[0]), 1);
        @(negedge clk);

        bus.en_pwm_lo = 8'h01;
        bus.duty = 8'd64;
        wait_ps(k);
        measure(-1, 8'd0, hi, pm);
        chk("static_to_pwm_window", hi, 129);
        measure(100, 8'd192, hi, pm);
        chk("deferred_pending_mid", pm, 1);
        chk("deferred_old_duty64", hi, 128);
        measure(-1, 8'd0, hi, pm);
        chk("deferred_new_duty192", hi, 384);
        chk("deferred_pending_clear", int'(bus.update_pending), 0);

        bus.duty = 8'd0;
        wait_ps(k);
        measure(-1, 8'd0, hi, pm);
        chk("duty0_high", hi, 0);
        bus.duty = 8'hFF;
        wait_ps(k);
        measure(-1, 8'd0, hi, pm);
        chk("duty255_first_window", hi, 511);
        measure(-1, 8'd0, hi, pm);
        chk("duty255_full", hi, 512);
        bus.duty = 8'd1;
        wait_ps(k);
        measure(-1, 8'd0, hi, pm);
        chk("duty1_after_full", hi, 3);
        measure(511, 8'd32, hi, pm);
        chk("race_old_duty1", hi, 2);
        measure(-1, 8'd0, hi, pm);
        chk("race_new_duty32", hi, 64);

        rand_cycles(4000);
      end
      begin
        int k2, h0, h15;
        k2 = 0;
        while (!bus2.period_start && k2 < 8000) begin
          @(negedge clk);
          k2++;
        end
        chk("p13_first_start", int'(bus2.period_start), 1);
        repeat (2) begin
          k2 = 0; h0 = 0; h15 = 0;
          do begin
            if (bus2.ch[0]) h0++;
            if (bus2.ch[15]) h15++;
            @(negedge clk);
            k2++;
          end while (!bus2.period_start && k2 < 8000);
          chk("p13_period_clks", k2, 3328);
          chk("p13_ch0_high", h0, 1300);
          chk("p13_ch15_high", h15, 1300);
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
